// File: rtl/bcd_operand_order_if.sv
// rtl/bcd_operand_order_if.sv - operand/result handshake bundle for bcd_operand_order
interface bcd_operand_order_if #(
    parameter int NDIG = 3
);
    localparam int W = 4 * NDIG;

    // operand side
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic         sign_a;
    logic         sign_b;
    logic         op_sub;

    // result side
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] mag_big;
    logic [W-1:0] mag_small;
    logic         eff_sub;
    logic         res_sign;
    logic         swap;
    logic         res_zero;
    logic         bcd_err;

    modport master (
        output in_valid, mag_a, mag_b, sign_a, sign_b, op_sub, out_ready,
        input  in_ready, out_valid, mag_big, mag_small, eff_sub, res_sign,
               swap, res_zero, bcd_err
    );

    modport slave (
        input  in_valid, mag_a, mag_b, sign_a, sign_b, op_sub, out_ready,
        output in_ready, out_valid, mag_big, mag_small, eff_sub, res_sign,
               swap, res_zero, bcd_err
    );
endinterface

// File: rtl/bcd_operand_order.sv
// rtl/bcd_operand_order.sv - sign/magnitude ordering front end of the signed BCD adder; optional digit check under BCD_CHECK_EN
module bcd_operand_order #(
    parameter int NDIG = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_operand_order_if.slave   bus,
    output logic [3:0]           cmp_a,
    output logic [3:0]           cmp_b,
    input  logic                 cmp_less,
    input  logic                 cmp_equal,
    input  logic                 cmp_greater
);
    localparam int W  = 4 * NDIG;
    localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_MSD = KW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [KW-1:0] k_dn;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sign_a_q;
    logic          sign_b_q;
    logic          op_sub_q;

    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  mag_big_q;
    logic [W-1:0]  mag_small_q;
    logic          eff_sub_q;
    logic          res_sign_q;
    logic          swap_q;
    logic          res_zero_q;

    logic          eff_in;
    logic          flags_onehot;
    logic          a_gt;
    logic          a_lt;

    // Effective operation of the operand set currently on the bus
    assign eff_in = bus.sign_a ^ bus.sign_b ^ bus.op_sub;

    // A malformed comparator answer (no flag or several flags) counts as equal
    assign flags_onehot = ({1'b0, cmp_less} + {1'b0, cmp_equal} + {1'b0, cmp_greater}) == 2'd1;
    assign a_gt         = flags_onehot & cmp_greater;
    assign a_lt         = flags_onehot & cmp_less;

    assign k_dn = k - 1'b1;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.mag_big   = mag_big_q;
    assign bus.mag_small = mag_small_q;
    assign bus.eff_sub   = eff_sub_q;
    assign bus.res_sign  = res_sign_q;
    assign bus.swap      = swap_q;
    assign bus.res_zero  = res_zero_q;

`ifdef BCD_CHECK_EN
    logic bcd_err_q;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Digit error is judged once per operand set and held until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_err_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            bcd_err_q <= has_bad_digit(bus.mag_a) | has_bad_digit(bus.mag_b);
        end
    end

    assign bus.bcd_err = bcd_err_q;
`else
    assign bus.bcd_err = 1'b0;
`endif

    // Control FSM: capture, MSD-first magnitude scan, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            op_sub_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mag_big_q   <= '0;
            mag_small_q <= '0;
            eff_sub_q   <= 1'b0;
            res_sign_q  <= 1'b0;
            swap_q      <= 1'b0;
            res_zero_q  <= 1'b0;
            cmp_a       <= 4'd0;
            cmp_b       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.mag_a;
                        b_q        <= bus.mag_b;
                        sign_a_q   <= bus.sign_a;
                        sign_b_q   <= bus.sign_b;
                        op_sub_q   <= bus.op_sub;
                        eff_sub_q  <= eff_in;
                        in_ready_q <= 1'b0;
                        swap_q     <= 1'b0;
                        res_zero_q <= 1'b0;
                        if (eff_in) begin
                            // Present the MSD now so the comparator answers on the first SCAN cycle
                            k     <= K_MSD;
                            cmp_a <= bus.mag_a[4*(NDIG-1) +: 4];
                            cmp_b <= bus.mag_b[4*(NDIG-1) +: 4];
                            state <= SCAN;
                        end else begin
                            // Same-sign addition: order is irrelevant, sign follows A
                            mag_big_q   <= bus.mag_a;
                            mag_small_q <= bus.mag_b;
                            res_sign_q  <= bus.sign_a;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end

                SCAN: begin
                    if (a_gt) begin
                        swap_q      <= 1'b0;
                        mag_big_q   <= a_q;
                        mag_small_q <= b_q;
                        res_sign_q  <= sign_a_q;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (a_lt) begin
                        // B dominates: result takes the sign B contributes after op_sub
                        swap_q      <= 1'b1;
                        mag_big_q   <= b_q;
                        mag_small_q <= a_q;
                        res_sign_q  <= sign_b_q ^ op_sub_q;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (k == '0) begin
                        // Equal magnitudes cancel to +0
                        swap_q      <= 1'b0;
                        res_zero_q  <= 1'b1;
                        mag_big_q   <= a_q;
                        mag_small_q <= b_q;
                        res_sign_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        k     <= k_dn;
                        cmp_a <= a_q[4*int'(k_dn) +: 4];
                        cmp_b <= b_q[4*int'(k_dn) +: 4];
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_operand_order.sv
// tb/tb_bcd_operand_order.sv - randomized self-checking bench for bcd_operand_order
module tb_bcd_operand_order;
    localparam int NDIG = 3;
    localparam int W    = 4 * NDIG;
    localparam int OW   = 2 * W + 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic       cmp_less;
    logic       cmp_equal;
    logic       cmp_greater;
    int         cmp_mode = 0;

    int passed = 0;
    int total  = 0;

    bcd_operand_order_if #(.NDIG(NDIG)) bus ();

    bcd_operand_order #(.NDIG(NDIG)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_less    (cmp_less),
        .cmp_equal   (cmp_equal),
        .cmp_greater (cmp_greater)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit comparator, with modes that produce malformed flags
    always_comb begin
        case (cmp_mode)
            1:       {cmp_less, cmp_equal, cmp_greater} = 3'b000;
            2:       {cmp_less, cmp_equal, cmp_greater} = 3'b111;
            default: {cmp_less, cmp_equal, cmp_greater} = {cmp_a < cmp_b, cmp_a == cmp_b, cmp_a > cmp_b};
        endcase
    end

    function automatic int digit_of(input int v, input int i);
        int p;
        p = 1;
        for (int n = 0; n < i; n++) p = p * 10;
        return (v / p) % 10;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'(digit_of(v, i));
        return r;
    endfunction

    // Reference: decide ordering from decimal values, count scanned digits from the top
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sa, input logic sb, input logic op,
                                  input logic flags_bad,
                                  output logic [OW-1:0] e, output int lat);
        int   va, vb, j;
        logic eff, sw, zero, sgn, err;
        va  = bcd2int(a);
        vb  = bcd2int(b);
        eff = sa ^ sb ^ op;
        err = 1'b0;
`ifdef BCD_CHECK_EN
        for (int i = 0; i < NDIG; i++) if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) err = 1'b1;
`endif
        if (!eff) begin
            e   = {a, b, 1'b0, sa, 1'b0, 1'b0, err};
            lat = 1;
        end else begin
            j = NDIG;
            if (!flags_bad) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (digit_of(va, i) != digit_of(vb, i)) j = NDIG - i;
                end
            end
            sw   = !flags_bad && (vb > va);
            zero = flags_bad || (va == vb);
            sgn  = zero ? 1'b0 : (sw ? (sb ^ op) : sa);
            e    = {sw ? b : a, sw ? a : b, 1'b1, sgn, sw, zero, err};
            lat  = 1 + j;
        end
    endfunction

    function automatic logic [OW-1:0] observe();
        return {bus.mag_big, bus.mag_small, bus.eff_sub, bus.res_sign, bus.swap, bus.res_zero, bus.bcd_err};
    endfunction

    // Offer one operand set, then wait (bounded) for out_valid
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sa, input logic sb, input logic op, input logic rdy,
                          output int lat, output logic [OW-1:0] obs, output logic rdy_at_offer);
        @(negedge clk);
        bus.mag_a     = a;
        bus.mag_b     = b;
        bus.sign_a    = sa;
        bus.sign_b    = sb;
        bus.op_sub    = op;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy;
        rdy_at_offer  = bus.in_ready;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mag_a    = W'($urandom);
        bus.mag_b    = W'($urandom);
        bus.sign_a   = 1'($urandom);
        bus.sign_b   = 1'($urandom);
        bus.op_sub   = 1'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        obs = observe();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        else passed++;
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        else passed++;
        total++;
        if (observe() !== '0) $display("FAIL reset_outputs: got %h expected 0", observe());
        else passed++;
        total++;
        if ({cmp_a, cmp_b} !== 8'h00) $display("FAIL reset_cmp: got %h expected 00", {cmp_a, cmp_b});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0]  ta [4] = '{12'h123, 12'h120, 12'h700, 12'h456};
        logic [W-1:0]  tb [4] = '{12'h045, 12'h125, 12'h300, 12'h456};
        logic [2:0]    tso[4] = '{3'b000, 3'b001, 3'b100, 3'b001};
        int            tl [4] = '{1, 4, 2, 4};
        logic [OW-1:0] e, obs;
        int            lat, mlat;
        logic          r;
        for (int i = 0; i < 4; i++) begin
            model(ta[i], tb[i], tso[i][2], tso[i][1], tso[i][0], 1'b0, e, mlat);
            do_txn(ta[i], tb[i], tso[i][2], tso[i][1], tso[i][0], 1'b1, lat, obs, r);
            total++;
            if (obs !== e) $display("FAIL directed%0d_fields: got %h expected %h", i, obs, e);
            else passed++;
            total++;
            if (lat !== tl[i]) $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, tl[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0]  a, b;
        logic          sa, sb, op, r;
        logic [OW-1:0] e, obs;
        int            lat, mlat, va, vb;
        for (int n = 0; n < 40; n++) begin
            va = $urandom_range(0, 999);
            case ($urandom_range(0, 3))
                0:       vb = va;
                1:       vb = (va / 10) * 10 + $urandom_range(0, 9);
                2:       vb = (va / 100) * 100 + $urandom_range(0, 99);
                default: vb = $urandom_range(0, 999);
            endcase
            a  = int2bcd(va);
            b  = int2bcd(vb);
            sa = 1'($urandom);
            sb = 1'($urandom);
            op = 1'($urandom);
            model(a, b, sa, sb, op, 1'b0, e, mlat);
            do_txn(a, b, sa, sb, op, 1'b1, lat, obs, r);
            total++;
            if (r !== 1'b1) $display("FAIL random%0d_in_ready: got %b expected 1", n, r);
            else passed++;
            total++;
            if (obs !== e || lat !== mlat)
                $display("FAIL random%0d: got %h lat %0d expected %h lat %0d", n, obs, lat, e, mlat);
            else passed++;
        end
    endtask

    task automatic test_bad_flags();
        logic [OW-1:0] e, obs;
        int            lat, mlat;
        logic          r;
        for (int m = 1; m <= 2; m++) begin
            cmp_mode = m;
            model(12'h732, 12'h158, 1'b0, 1'b0, 1'b1, 1'b1, e, mlat);
            do_txn(12'h732, 12'h158, 1'b0, 1'b0, 1'b1, 1'b1, lat, obs, r);
            total++;
            if (obs !== e || lat !== mlat)
                $display("FAIL bad_flags%0d: got %h lat %0d expected %h lat %0d", m, obs, lat, e, mlat);
            else passed++;
        end
        cmp_mode = 0;
    endtask

    task automatic test_stall();
        logic [OW-1:0] e, obs;
        int            lat, mlat, bad;
        logic          r;
        model(12'h123, 12'h045, 1'b0, 1'b0, 1'b1, 1'b0, e, mlat);
        do_txn(12'h123, 12'h045, 1'b0, 1'b0, 1'b1, 1'b0, lat, obs, r);
        total++;
        if (obs !== e || lat !== mlat)
            $display("FAIL stall_result: got %h lat %0d expected %h lat %0d", obs, lat, e, mlat);
        else passed++;
        bad = 0;
        bus.in_valid = 1'b1;
        bus.mag_a    = 12'h999;
        bus.sign_b   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (observe() !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
        else passed++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL stall_release: got valid/ready %b expected 01", {bus.out_valid, bus.in_ready});
        else passed++;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL stall_no_accept_in_done: got valid/ready %b expected 01", {bus.out_valid, bus.in_ready});
        else passed++;
    endtask

    task automatic test_rst_mid();
        int            seen;
        int            lat;
        logic [OW-1:0] obs;
        logic          r;
        @(negedge clk);
        bus.mag_a     = 12'h456;
        bus.mag_b     = 12'h456;
        bus.sign_a    = 1'b0;
        bus.sign_b    = 1'b0;
        bus.op_sub    = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid, observe(), cmp_a, cmp_b} !== {1'b1, 1'b0, {OW{1'b0}}, 8'h00})
            $display("FAIL rst_mid_scan: got rdy %b vld %b out %h cmp %h expected 1 0 0 00",
                     bus.in_ready, bus.out_valid, observe(), {cmp_a, cmp_b});
        else passed++;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL rst_mid_scan_no_valid: got %0d valid cycles expected 0", seen);
        else passed++;
        do_txn(12'h321, 12'h654, 1'b1, 1'b0, 1'b0, 1'b0, lat, obs, r);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid, observe()} !== {1'b1, 1'b0, {OW{1'b0}}})
            $display("FAIL rst_mid_done: got rdy %b vld %b out %h expected 1 0 0",
                     bus.in_ready, bus.out_valid, observe());
        else passed++;
        bus.out_ready = 1'b1;
    endtask

`ifdef BCD_CHECK_EN
    task automatic test_bcd_err();
        logic [OW-1:0] obs;
        int            lat;
        logic          r;
        do_txn(12'h1A3, 12'h045, 1'b0, 1'b0, 1'b0, 1'b1, lat, obs, r);
        total++;
        if (obs[0] !== 1'b1) $display("FAIL bcd_err_set: got %b expected 1", obs[0]);
        else passed++;
        do_txn(12'h123, 12'h045, 1'b0, 1'b0, 1'b0, 1'b1, lat, obs, r);
        total++;
        if (obs[0] !== 1'b0) $display("FAIL bcd_err_clear: got %b expected 0", obs[0]);
        else passed++;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.mag_a     = '0;
        bus.mag_b     = '0;
        bus.sign_a    = 1'b0;
        bus.sign_b    = 1'b0;
        bus.op_sub    = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_bad_flags();
        test_stall();
        test_rst_mid();
`ifdef BCD_CHECK_EN
        test_bcd_err();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
